// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg
//   Shared types and constants for the push-button debouncer.
//   deb_state_t   : per-channel debounce FSM states
//   KEY_PRESSED   : pin level of a pressed key (buttons are active-low)
//   KEY_RELEASED  : pin level of a released key
package key_debounce_pkg;

  typedef enum logic [1:0] {
    REL_STABLE   = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRS_STABLE   = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/key_debounce_chan.sv
// key_debounce_chan
//   One key channel: two-flop synchroniser, 4-state debounce FSM with a
//   stability counter, and registered level/strobe outputs.
//   clk           : system clock, rising edge
//   reset         : synchronous, active-high
//   key_raw       : asynchronous pin, active-low
//   key_out       : debounced level, active-low, registered
//   press_pulse   : one-cycle strobe on accepted press (1->0)
//   release_pulse : one-cycle strobe on accepted release (0->1)
module key_debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_out_q, key_out_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    s1_d      = key_raw;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_out_d = key_out_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      REL_STABLE: begin
        if (s2_q == KEY_PRESSED) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        // Any bounce back to released restarts the full window.
        if (s2_q == KEY_RELEASED) begin
          state_d = REL_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = PRS_STABLE;
          cnt_d     = '0;
          key_out_d = KEY_PRESSED;
          press_d   = 1'b1;
        end else begin
          // Only incremented while below CNT_MAX, so it never wraps.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRS_STABLE: begin
        if (s2_q == KEY_RELEASED) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2_q == KEY_PRESSED) begin
          state_d = PRS_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = REL_STABLE;
          cnt_d     = '0;
          key_out_d = KEY_RELEASED;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = REL_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= KEY_RELEASED;
      s2_q      <= KEY_RELEASED;
      state_q   <= REL_STABLE;
      cnt_q     <= '0;
      key_out_q <= KEY_RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_out_q <= key_out_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_out       = key_out_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/key_debounce.sv
// key_debounce
//   Synchroniser and debouncer for NUM_KEYS active-low push-buttons; feeds
//   the key PIO so its falling-edge capture sees one edge per press.
//   clk           : system clock, rising edge
//   reset         : synchronous, active-high
//   key_raw       : asynchronous button pins, active-low
//   key_out       : debounced levels, active-low (PIO in_port)
//   press_pulse   : per-key one-cycle strobe on accepted press
//   release_pulse : per-key one-cycle strobe on accepted release
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_out,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse
);

  // Parameter sanity: the window must be at least two cycles and the
  // counter must be able to hold DEBOUNCE_CYCLES-1.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end
  if (CNT_W < 1 || CNT_W > 62 ||
      64'(DEBOUNCE_CYCLES - 1) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
    $error("key_debounce: CNT_W too small for DEBOUNCE_CYCLES");
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
    key_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .key_raw      (key_raw[gi]),
      .key_out      (key_out[gi]),
      .press_pulse  (press_pulse[gi]),
      .release_pulse(release_pulse[gi])
    );
  end

endmodule
